// File: rtl/softmax_row_packer_if.sv
// Bundle of the row-packer stream, tree and output handshakes.
// The packer uses the slave view; whatever drives it uses the master view.
interface softmax_row_packer_if #(
  parameter int N  = 64,
  parameter int LW = $clog2(N + 1)
);
  logic            s_valid;
  logic            s_ready;
  logic [15:0]     s_data;
  logic            s_last;
  logic            tree_ready;
  logic [N*16-1:0] tree_flat;
  logic            tree_valid;
  logic [15:0]     tree_sum;
  logic            m_valid;
  logic            m_ready;
  logic [N*16-1:0] m_flat;
  logic [15:0]     m_sum;
  logic [LW-1:0]   m_len;
  logic            err;

  modport slave (
    input  s_valid, s_data, s_last, tree_valid, tree_sum, m_ready,
    output s_ready, tree_ready, tree_flat, m_valid, m_flat, m_sum, m_len, err
  );

  modport master (
    output s_valid, s_data, s_last, tree_valid, tree_sum, m_ready,
    input  s_ready, tree_ready, tree_flat, m_valid, m_flat, m_sum, m_len, err
  );
endinterface

// File: rtl/softmax_row_packer.sv
// Packs a serial FP16 stream into zero-padded N-lane rows, feeds them to the
// adder tree one at a time and pairs each row with its returned sum.
module softmax_row_packer #(
  parameter int N  = 64,
  parameter int LW = $clog2(N + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  softmax_row_packer_if.slave  bus
);
  localparam int CW = $clog2(N);

  typedef enum logic [2:0] {
    ST_EMPTY   = 3'd0,
    ST_FILL    = 3'd1,
    ST_QUEUED  = 3'd2,
    ST_IN_TREE = 3'd3,
    ST_DONE    = 3'd4
  } bank_state_e;

  bank_state_e   state_q [2];
  logic [15:0]   lane_q  [2][N];
  logic [15:0]   sum_q   [2];
  logic [LW-1:0] len_q   [2];
  logic          wr_ptr_q;
  logic          tr_ptr_q;
  logic          rd_ptr_q;
  logic [CW-1:0] cnt_q;
  logic          tree_ready_q;
  logic          err_q;

  logic accept;
  logic close_row;
  logic tree_busy;
  logic in_tree_sel;
  logic issue_direct;
  logic issue;
  logic ret_ok;
  logic out_valid;
  logic release_row;

  assign tree_busy   = (state_q[0] == ST_IN_TREE) || (state_q[1] == ST_IN_TREE);
  assign in_tree_sel = (state_q[1] == ST_IN_TREE);

  assign bus.s_ready = rst && ((state_q[wr_ptr_q] == ST_EMPTY) ||
                               (state_q[wr_ptr_q] == ST_FILL));
  assign accept      = bus.s_valid && bus.s_ready;
  assign close_row   = accept && (bus.s_last || (cnt_q == CW'(N - 1)));

  // A row closing into the next-to-issue bank may go straight into an idle
  // tree, so the start pulse follows the closing word by one cycle.
  assign issue_direct = close_row && (wr_ptr_q == tr_ptr_q);
  assign issue        = !tree_busy && ((state_q[tr_ptr_q] == ST_QUEUED) || issue_direct);

  assign ret_ok      = bus.tree_valid && tree_busy;
  assign out_valid   = (state_q[rd_ptr_q] == ST_DONE);
  assign release_row = out_valid && bus.m_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q     <= 1'b0;
      tr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      cnt_q        <= '0;
      tree_ready_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      if (accept) begin
        cnt_q <= close_row ? '0 : cnt_q + CW'(1);
      end
      if (close_row) begin
        wr_ptr_q <= !wr_ptr_q;
      end
      if (issue) begin
        tr_ptr_q <= !tr_ptr_q;
      end
      if (release_row) begin
        rd_ptr_q <= !rd_ptr_q;
      end
      tree_ready_q <= issue;
      if (bus.tree_valid && !tree_busy) begin
        err_q <= 1'b1;
      end
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    localparam logic SEL = 1'(gi);

    // Each bank sees at most one lifecycle event per cycle, since every
    // event requires a different current state.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        state_q[gi] <= ST_EMPTY;
        sum_q[gi]   <= '0;
        len_q[gi]   <= '0;
      end else if (accept && (wr_ptr_q == SEL)) begin
        if (close_row) begin
          len_q[gi]   <= LW'(cnt_q) + LW'(1);
          state_q[gi] <= (issue && (tr_ptr_q == SEL)) ? ST_IN_TREE : ST_QUEUED;
        end else begin
          state_q[gi] <= ST_FILL;
        end
      end else if (issue && (tr_ptr_q == SEL)) begin
        state_q[gi] <= ST_IN_TREE;
      end else if (ret_ok && (in_tree_sel == SEL)) begin
        state_q[gi] <= ST_DONE;
        sum_q[gi]   <= bus.tree_sum;
      end else if (release_row && (rd_ptr_q == SEL)) begin
        state_q[gi] <= ST_EMPTY;
      end
    end

    for (genvar li = 0; li < N; li++) begin : g_lane
      // Lanes past the closing word are zeroed so stale data never reaches the sum.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          lane_q[gi][li] <= '0;
        end else if (accept && (wr_ptr_q == SEL)) begin
          if (cnt_q == CW'(li)) begin
            lane_q[gi][li] <= bus.s_data;
          end else if (close_row && (cnt_q < CW'(li))) begin
            lane_q[gi][li] <= '0;
          end
        end
      end
    end
  end

  for (genvar li = 0; li < N; li++) begin : g_flat
    assign bus.tree_flat[li*16 +: 16] = tree_busy ? lane_q[in_tree_sel][li] : 16'h0000;
    assign bus.m_flat[li*16 +: 16]    = out_valid ? lane_q[rd_ptr_q][li] : 16'h0000;
  end

  assign bus.tree_ready = tree_ready_q;
  assign bus.m_valid    = out_valid;
  assign bus.m_sum      = out_valid ? sum_q[rd_ptr_q] : 16'h0000;
  assign bus.m_len      = out_valid ? len_q[rd_ptr_q] : '0;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_softmax_row_packer.sv
// Self-checking bench for softmax_row_packer at N=4: table-driven rows with a
// scoreboard, plus hand-written back-pressure, simultaneous-event and reset sequences.
module tb_softmax_row_packer;
  localparam int N  = 4;
  localparam int LW = 3;

  typedef struct {
    logic [63:0] w;
    int          len;
    bit          use_last;
    logic [15:0] sum;
  } vec_t;

  typedef struct {
    logic [63:0]   flat;
    logic [15:0]   sum;
    logic [LW-1:0] len;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  softmax_row_packer_if #(.N(N), .LW(LW)) bus ();
  softmax_row_packer #(.N(N), .LW(LW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int   checks = 0;
  int   passes = 0;
  exp_t sb[$];
  vec_t vecs[6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %h, required %h", nm, act, req);
  endtask

  function automatic exp_t make_exp(input vec_t v);
    exp_t e;
    e.flat = '0;
    for (int i = 0; i < N; i++)
      if (i < v.len) e.flat[i*16 +: 16] = v.w[i*16 +: 16];
    e.sum = v.sum;
    e.len = LW'(v.len);
    return e;
  endfunction

  task automatic send_word(input logic [15:0] d, input bit last);
    int guard;
    guard = 0;
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.s_last  = last;
    while (bus.s_ready !== 1'b1 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 40) chk("s_ready_timeout", 64'(bus.s_ready), 64'd1);
    @(negedge clk);
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic send_row(input vec_t v);
    for (int i = 0; i < v.len; i++)
      send_word(v.w[i*16 +: 16], v.use_last && (i == v.len - 1));
  endtask

  task automatic tree_return(input logic [15:0] s);
    bus.tree_valid = 1'b1;
    bus.tree_sum   = s;
    @(negedge clk);
    bus.tree_valid = 1'b0;
    bus.tree_sum   = 16'h0000;
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      $display("FAIL scoreboard_underflow: got m_valid=%0b, required a queued row", bus.m_valid);
    end else begin
      e = sb.pop_front();
      chk("m_valid", 64'(bus.m_valid), 64'd1);
      chk("m_flat",  bus.m_flat, e.flat);
      chk("m_sum",   64'(bus.m_sum), 64'(e.sum));
      chk("m_len",   64'(bus.m_len), 64'(e.len));
      $display("row out: len=%0d sum=%h flat=%h", bus.m_len, bus.m_sum, bus.m_flat);
    end
  endtask

  task automatic release_out();
    bus.m_ready = 1'b1;
    @(negedge clk);
    bus.m_ready = 1'b0;
  endtask

  task automatic run_row(input vec_t v, input int lat);
    exp_t e;
    e = make_exp(v);
    sb.push_back(e);
    send_row(v);
    chk("tree_ready_pulse", 64'(bus.tree_ready), 64'd1);
    chk("tree_flat", bus.tree_flat, e.flat);
    @(negedge clk);
    chk("tree_ready_single", 64'(bus.tree_ready), 64'd0);
    repeat (lat) @(negedge clk);
    chk("tree_flat_hold", bus.tree_flat, e.flat);
    tree_return(v.sum);
    pop_check();
    release_out();
    chk("m_valid_clear", 64'(bus.m_valid), 64'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t r1, r2, r3, va, vb, vc, vd, vf;
    vecs[0] = '{64'h4400_4200_4000_3C00, 4, 1'b0, 16'h4900};
    vecs[1] = '{64'h0000_0000_3C00_3C00, 2, 1'b1, 16'h4000};
    vecs[2] = '{64'h0000_0000_0000_4500, 1, 1'b1, 16'h4500};
    vecs[3] = '{64'h0000_4000_4000_4000, 3, 1'b1, 16'h4600};
    vecs[4] = '{64'h3C00_3C00_3C00_3C00, 4, 1'b1, 16'h4400};
    vecs[5] = '{64'h0000_0000_4200_3800, 2, 1'b1, 16'h4300};
    r1 = '{64'h4400_4400_4400_4400, 4, 1'b0, 16'h4C00};
    r2 = '{64'h4000_3C00_4000_3C00, 4, 1'b0, 16'h4600};
    r3 = '{64'h0000_0000_0000_4000, 1, 1'b1, 16'h4000};
    va = '{64'h0000_0000_4000_4000, 2, 1'b1, 16'h4400};
    vb = '{64'h0000_3C00_3C00_3C00, 3, 1'b1, 16'h4200};
    vc = '{64'h4000_4000_4000_4000, 4, 1'b0, 16'h4800};
    vd = '{64'h4000_4000_4000_4000, 4, 1'b0, 16'h4800};
    vf = '{64'h0000_0000_4500_4200, 2, 1'b1, 16'h4800};

    bus.s_valid = 1'b0; bus.s_data = '0; bus.s_last = 1'b0;
    bus.tree_valid = 1'b0; bus.tree_sum = '0; bus.m_ready = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state.
    chk("rst_s_ready",    64'(bus.s_ready), 64'd0);
    chk("rst_m_valid",    64'(bus.m_valid), 64'd0);
    chk("rst_err",        64'(bus.err), 64'd0);
    chk("rst_tree_ready", 64'(bus.tree_ready), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_s_ready",   64'(bus.s_ready), 64'd1);
    chk("idle_tree_flat", bus.tree_flat, 64'd0);
    chk("idle_m_flat",    bus.m_flat, 64'd0);

    // Spurious return while idle.
    tree_return(16'hDEAD);
    chk("spurious_err",     64'(bus.err), 64'd1);
    chk("spurious_m_valid", 64'(bus.m_valid), 64'd0);

    // Table of rows, one at a time through the whole pipeline.
    for (int i = 0; i < 6; i++) run_row(vecs[i], i % 3);
    chk("err_sticky", 64'(bus.err), 64'd1);

    // Ping-pong back-pressure with the output stalled.
    sb.push_back(make_exp(r1));
    send_row(r1);
    chk("bp_r1_issue", 64'(bus.tree_ready), 64'd1);
    sb.push_back(make_exp(r2));
    send_row(r2);
    chk("bp_s_ready_drop", 64'(bus.s_ready), 64'd0);
    chk("bp_r2_not_issued", 64'(bus.tree_ready), 64'd0);
    chk("bp_tree_holds_r1", bus.tree_flat, make_exp(r1).flat);
    bus.s_valid = 1'b1; bus.s_data = r3.w[15:0]; bus.s_last = 1'b1;
    repeat (2) @(negedge clk);
    chk("bp_r3_blocked", 64'(bus.s_ready), 64'd0);
    bus.s_valid = 1'b0; bus.s_last = 1'b0;
    tree_return(r1.sum);
    chk("bp_r2_wait_edge", 64'(bus.tree_ready), 64'd0);
    @(negedge clk);
    chk("bp_r2_issue", 64'(bus.tree_ready), 64'd1);
    chk("bp_r2_flat", bus.tree_flat, make_exp(r2).flat);
    tree_return(r2.sum);
    chk("bp_both_done_s_ready", 64'(bus.s_ready), 64'd0);
    pop_check();
    release_out();
    chk("bp_r3_can_enter", 64'(bus.s_ready), 64'd1);
    pop_check();
    release_out();
    run_row(r3, 1);

    // Output release and tree return in the same cycle.
    sb.push_back(make_exp(va));
    send_row(va);
    chk("sim_a_issue", 64'(bus.tree_ready), 64'd1);
    tree_return(va.sum);
    sb.push_back(make_exp(vb));
    send_row(vb);
    chk("sim_b_issue", 64'(bus.tree_ready), 64'd1);
    chk("sim_b_flat", bus.tree_flat, make_exp(vb).flat);
    bus.s_valid = 1'b1; bus.s_data = vc.w[15:0]; bus.s_last = 1'b0;
    chk("sim_s_ready_blocked", 64'(bus.s_ready), 64'd0);
    pop_check();
    bus.m_ready = 1'b1; bus.tree_valid = 1'b1; bus.tree_sum = vb.sum;
    @(negedge clk);
    bus.m_ready = 1'b0; bus.tree_valid = 1'b0; bus.tree_sum = '0;
    pop_check();
    chk("sim_refill_ready", 64'(bus.s_ready), 64'd1);
    bus.s_valid = 1'b0;
    release_out();
    run_row(vc, 0);

    // Asynchronous reset with one row in the tree and another half filled.
    send_row(vd);
    chk("rst_mid_tree_flat", bus.tree_flat, make_exp(vd).flat);
    send_word(16'h3C00, 1'b0);
    send_word(16'h3C00, 1'b0);
    #2 rst = 1'b0;
    #1;
    chk("arst_s_ready",    64'(bus.s_ready), 64'd0);
    chk("arst_tree_ready", 64'(bus.tree_ready), 64'd0);
    chk("arst_tree_flat",  bus.tree_flat, 64'd0);
    chk("arst_m_valid",    64'(bus.m_valid), 64'd0);
    chk("arst_err",        64'(bus.err), 64'd0);
    sb.delete();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("arst_release_s_ready", 64'(bus.s_ready), 64'd1);
    tree_return(16'hBEEF);
    chk("late_return_err",     64'(bus.err), 64'd1);
    chk("late_return_m_valid", 64'(bus.m_valid), 64'd0);
    run_row(vf, 2);

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
